// File: rtl/soc_system_mosfet_sequencer.sv
// soc_system_mosfet_sequencer
//   Avalon-MM slave that drives the heater MOSFET gate from a PWM sequencer.
//   The sequencer has a software watchdog and a door/over-temperature
//   interlock, so the gate drops if the HPS stalls or the chamber opens.
//
// Ports:
//   clk        - single clock for all logic
//   reset      - synchronous, active-high
//   address    - register select (0 CTRL, 1 PERIOD, 2 DUTY, 3 WDT, 4 STATUS)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - combinational read data, zero wait states
//   interlock  - asynchronous unsafe indication (high = unsafe)
//   mosfet_en  - registered MOSFET gate enable
//   irq        - registered, high while any fault flag is set
module soc_system_mosfet_sequencer #(
  parameter int PRESCALE = 50,
  parameter int WDT_W    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        interlock,
  output logic        mosfet_en,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic               enable_r;
  logic [15:0]        period_r;
  logic [15:0]        duty_r;
  logic [WDT_W-1:0]   wdt_r;
  logic               fault_wdt_r;
  logic               fault_ilk_r;

  logic [PW-1:0]      presc_r;
  logic [15:0]        phase_r;
  logic [15:0]        sh_period_r;
  logic [15:0]        sh_duty_r;
  logic [WDT_W-1:0]   wdt_cnt_r;

  logic               ilk_meta_r;
  logic               ilk_sync_r;

  logic               wr_s;
  logic               wr_ctrl_s;
  logic               kick_s;
  logic               clear_s;
  logic               tick_s;
  logic               wdt_expire_s;
  logic               period_wrap_s;
  logic               set_wdt_s;
  logic               set_ilk_s;
  logic               clr_flags_s;
  logic               enter_run_s;
  logic               unused_wdata_s;

  assign wr_s      = chipselect && !write_n;
  assign wr_ctrl_s = wr_s && (address == 3'd0);
  assign kick_s    = wr_ctrl_s && writedata[2];
  assign clear_s   = wr_ctrl_s && writedata[1];
  assign tick_s    = (presc_r == PRESC_MAX);

  // A kick landing on the expiry edge wins, so it masks the expiry here.
  assign wdt_expire_s = (wdt_r != {WDT_W{1'b0}}) && (wdt_cnt_r >= wdt_r) && !kick_s;

  // PERIOD = 0 wraps every tick so the shadows keep following the live
  // registers instead of the phase counter running off to 0xFFFF.
  assign period_wrap_s = (sh_period_r == 16'd0) || (phase_r >= (sh_period_r - 16'd1));

  // Upper write-data bits beyond the widest register are intentionally ignored.
  assign unused_wdata_s = ^writedata;

  // Free-running prescaler producing one tick every PRESCALE clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous interlock input.
  always_ff @(posedge clk) begin
    if (reset) begin
      ilk_meta_r <= 1'b0;
      ilk_sync_r <= 1'b0;
    end else begin
      ilk_meta_r <= interlock;
      ilk_sync_r <= ilk_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode; fault conditions take priority over enable = 0.
  always_comb begin
    state_next_s = state_r;
    set_wdt_s    = 1'b0;
    set_ilk_s    = 1'b0;
    clr_flags_s  = 1'b0;
    enter_run_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_r && !fault_wdt_r && !fault_ilk_r && !ilk_sync_r) begin
          state_next_s = ST_RUN;
          enter_run_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        set_ilk_s = ilk_sync_r;
        set_wdt_s = wdt_expire_s;
        if (ilk_sync_r || wdt_expire_s) begin
          state_next_s = ST_FAULT;
        end else if (!enable_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (clear_s && !ilk_sync_r) begin
          state_next_s = ST_IDLE;
          clr_flags_s  = 1'b1;
        end else begin
          state_next_s = ST_FAULT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // CTRL enable bit; hardware forces it low on fault entry and while faulted
  // so software must re-enable explicitly after clearing a fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r <= 1'b0;
    end else if ((state_r == ST_FAULT) || (state_next_s == ST_FAULT)) begin
      enable_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      enable_r <= writedata[0];
    end else begin
      enable_r <= enable_r;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_r <= 16'd0;
      duty_r   <= 16'd0;
      wdt_r    <= {WDT_W{1'b0}};
    end else begin
      if (wr_s && (address == 3'd1)) begin
        period_r <= writedata[15:0];
      end
      if (wr_s && (address == 3'd2)) begin
        duty_r <= writedata[15:0];
      end
      if (wr_s && (address == 3'd3)) begin
        wdt_r <= writedata[WDT_W-1:0];
      end
    end
  end

  // Sticky fault flags; a clear on the same edge as a new fault loses
  // because a new fault can only arise in RUN, never in FAULT.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_wdt_r <= 1'b0;
      fault_ilk_r <= 1'b0;
    end else if (clr_flags_s) begin
      fault_wdt_r <= 1'b0;
      fault_ilk_r <= 1'b0;
    end else begin
      if (set_wdt_s) begin
        fault_wdt_r <= 1'b1;
      end
      if (set_ilk_s) begin
        fault_ilk_r <= 1'b1;
      end
    end
  end

  // PWM phase counter with shadow PERIOD/DUTY reloaded only at period ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r     <= 16'd0;
      sh_period_r <= 16'd0;
      sh_duty_r   <= 16'd0;
    end else if (enter_run_s) begin
      phase_r     <= 16'd0;
      sh_period_r <= period_r;
      sh_duty_r   <= duty_r;
    end else if ((state_r == ST_RUN) && tick_s) begin
      if (period_wrap_s) begin
        phase_r     <= 16'd0;
        sh_period_r <= period_r;
        sh_duty_r   <= duty_r;
      end else begin
        phase_r <= phase_r + 16'd1;
      end
    end
  end

  // Watchdog counter; saturates at the timeout so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end else if (enter_run_s) begin
      wdt_cnt_r <= {WDT_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      if (kick_s) begin
        wdt_cnt_r <= {WDT_W{1'b0}};
      end else if (tick_s && (wdt_cnt_r < wdt_r)) begin
        wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
      end
    end
  end

  // Registered outputs decoded from the current state and phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      mosfet_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      mosfet_en <= (state_r == ST_RUN) && (sh_period_r != 16'd0) && (phase_r < sh_duty_r);
      irq       <= fault_wdt_r | fault_ilk_r;
    end
  end

  // Zero-latency read mux; STATUS shows committed register state only.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0: readdata[0] = enable_r;
      3'd1: readdata[15:0] = period_r;
      3'd2: readdata[15:0] = duty_r;
      3'd3: readdata[WDT_W-1:0] = wdt_r;
      3'd4: readdata[5:0] = {state_r, 1'b0, fault_ilk_r, fault_wdt_r, mosfet_en};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_mosfet_sequencer.sv
// Self-checking bench for soc_system_mosfet_sequencer.
// Expected values come from the register-map rules and PWM/watchdog timing
// arithmetic (duty*PRESCALE high, (period-duty)*PRESCALE low, etc.).
module tb_soc_system_mosfet_sequencer;

  localparam int P  = 10;
  localparam int WW = 24;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_DUTY   = 3'd2;
  localparam logic [2:0] A_WDT    = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        interlock = 1'b0;
  logic        mosfet_en;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  soc_system_mosfet_sequencer #(.PRESCALE(P), .WDT_W(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .interlock  (interlock),
    .mosfet_en  (mosfet_en),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a write that is sampled on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0; address = 3'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0; address = 3'd0;
  endtask

  task automatic wait_level(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (mosfet_en === lvl) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic run_len(input logic lvl, input int bound, output int n);
    n = 0;
    while ((mosfet_en === lvl) && (n < bound)) begin
      step(1);
      n++;
    end
  endtask

  task automatic configure(input int per, input int du, input int w);
    wr(A_CTRL, 32'd0);
    step(2);
    wr(A_PERIOD, 32'(per));
    wr(A_DUTY, 32'(du));
    wr(A_WDT, 32'(w));
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    n_total++;
    if (mosfet_en !== 1'b0) $display("FAIL reset_mosfet: got %b want 0", mosfet_en); else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), v);
      n_total++;
      if (v !== 32'd0) $display("FAIL reset_reg%0d: got %h want 0", a, v); else n_pass++;
      step(1);
    end
  endtask

  task automatic test_registers;
    logic [31:0] model [0:7];
    logic [31:0] v;
    logic [31:0] d;
    int a;
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 7);
      d = $urandom;
      if (a == 0) d = d & 32'hFFFF_FFFE;
      wr(3'(a), d);
      case (a)
        1, 2: model[a] = {16'd0, d[15:0]};
        3: model[a] = {8'd0, d[23:0]};
        default: ;
      endcase
      rd(3'(a), v);
      n_total++;
      if (v !== model[a]) $display("FAIL reg_rw a=%0d: got %h want %h", a, v, model[a]); else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      step(1);
      rd(3'(k), v);
      n_total++;
      if (v !== model[k]) $display("FAIL reg_final a=%0d: got %h want %h", k, v, model[k]); else n_pass++;
    end
  endtask

  task automatic test_pwm(input int per, input int du);
    bit ok;
    int h;
    int l;
    int bound;
    bound = (per + 2) * P * 2;
    configure(per, du, 0);
    wr(A_CTRL, 32'd1);
    wait_level(1'b1, bound, ok);
    n_total++;
    if (!ok) $display("FAIL pwm_rise p=%0d d=%0d: got no rise want rise", per, du); else n_pass++;
    if (ok) begin
      run_len(1'b1, bound, h);
      run_len(1'b0, bound, l);
      run_len(1'b1, bound, h);
      n_total++;
      if (l != (per - du) * P) $display("FAIL pwm_low p=%0d d=%0d: got %0d want %0d", per, du, l, (per - du) * P);
      else n_pass++;
      n_total++;
      if (h != du * P) $display("FAIL pwm_high p=%0d d=%0d: got %0d want %0d", per, du, h, du * P);
      else n_pass++;
    end
  endtask

  task automatic test_duty_change;
    bit ok;
    int h;
    int l;
    test_pwm(10, 3);
    wait_level(1'b1, 30 * P, ok);
    step(5 * P);
    wr(A_DUTY, 32'd7);
    step(2);
    n_total++;
    if (mosfet_en !== 1'b0) $display("FAIL duty_midperiod: got %b want 0", mosfet_en); else n_pass++;
    wait_level(1'b1, 30 * P, ok);
    run_len(1'b1, 30 * P, h);
    run_len(1'b0, 30 * P, l);
    n_total++;
    if (h != 7 * P) $display("FAIL duty_new_high: got %0d want %0d", h, 7 * P); else n_pass++;
    n_total++;
    if (l != 3 * P) $display("FAIL duty_new_low: got %0d want %0d", l, 3 * P); else n_pass++;
  endtask

  task automatic test_edge_duties;
    int hi_cnt;
    int lo_cnt;
    logic [31:0] v;
    // DUTY = 0: never on.
    configure(10, 0, 0);
    wr(A_CTRL, 32'd1);
    step(4);
    hi_cnt = 0;
    for (int i = 0; i < 30 * P; i++) begin step(1); if (mosfet_en === 1'b1) hi_cnt++; end
    n_total++;
    if (hi_cnt != 0) $display("FAIL duty0_high: got %0d want 0", hi_cnt); else n_pass++;
    // DUTY > PERIOD: always on.
    configure(10, 12, 0);
    wr(A_CTRL, 32'd1);
    step(4);
    lo_cnt = 0;
    for (int i = 0; i < 30 * P; i++) begin step(1); if (mosfet_en !== 1'b1) lo_cnt++; end
    n_total++;
    if (lo_cnt != 0) $display("FAIL duty12_low: got %0d want 0", lo_cnt); else n_pass++;
    // PERIOD = 0: always off while RUN.
    configure(0, 5, 0);
    wr(A_CTRL, 32'd1);
    step(4);
    hi_cnt = 0;
    for (int i = 0; i < 10 * P; i++) begin step(1); if (mosfet_en === 1'b1) hi_cnt++; end
    n_total++;
    if (hi_cnt != 0) $display("FAIL period0_high: got %0d want 0", hi_cnt); else n_pass++;
    rd(A_STATUS, v);
    n_total++;
    if (v[5:4] !== 2'd1) $display("FAIL period0_state: got %0d want 1", v[5:4]); else n_pass++;
  endtask

  task automatic test_watchdog;
    logic [31:0] v;
    int w;
    int s;
    int s2;
    int d;
    int lo;
    int hi;
    bit found;
    w = $urandom_range(20, 60);
    configure(10, 3, w);
    wr(A_CTRL, 32'd1);
    s = cyc;
    found = 1'b0;
    for (int i = 0; i < w * P + 50; i++) begin
      rd(A_STATUS, v);
      if (v[5:4] == 2'd2) begin found = 1'b1; break; end
      step(1);
    end
    d  = cyc - s;
    lo = (w - 1) * P + 3;
    hi = w * P + 2;
    n_total++;
    if (!found || d < lo || d > hi) $display("FAIL wdt_latency w=%0d: got %0d want %0d..%0d", w, d, lo, hi);
    else n_pass++;
    step(2);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'h22) $display("FAIL wdt_status: got %h want 22", v); else n_pass++;
    n_total++;
    if (irq !== 1'b1 || mosfet_en !== 1'b0) $display("FAIL wdt_outputs: got irq=%b en=%b want irq=1 en=0", irq, mosfet_en);
    else n_pass++;
    rd(A_CTRL, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL wdt_enable_cleared: got %h want 0", v); else n_pass++;
    step(1);
    wr(A_CTRL, 32'd2);
    step(2);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'd0 || irq !== 1'b0) $display("FAIL wdt_clear: got status=%h irq=%b want 0/0", v, irq); else n_pass++;
    // Replay with the same prescaler alignment, kicking on the expiry edge.
    while (((cyc + 1) % P) != (s % P)) step(1);
    wr(A_CTRL, 32'd1);
    s2 = cyc;
    while (cyc < s2 + d - 1) step(1);
    wr(A_CTRL, 32'd5);
    step(3);
    rd(A_STATUS, v);
    n_total++;
    if ((v & 32'h36) !== 32'h10 || irq !== 1'b0) $display("FAIL kick_collision: got status=%h irq=%b want RUN no fault", v, irq);
    else n_pass++;
    wr(A_CTRL, 32'd0);
    step(2);
  endtask

  task automatic test_wdt_kicks;
    logic [31:0] v;
    configure(10, 3, 100);
    wr(A_CTRL, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(50 * P - 1);
      wr(A_CTRL, 32'd5);
    end
    rd(A_STATUS, v);
    n_total++;
    if ((v & 32'h36) !== 32'h10 || irq !== 1'b0) $display("FAIL wdt_kicked: got status=%h irq=%b want RUN no fault", v, irq);
    else n_pass++;
    wr(A_CTRL, 32'd0);
    step(2);
  endtask

  task automatic test_interlock;
    logic [31:0] v;
    int n;
    configure(10, 12, 0);
    wr(A_CTRL, 32'd1);
    step(6);
    n_total++;
    if (mosfet_en !== 1'b1) $display("FAIL ilk_pre_on: got %b want 1", mosfet_en); else n_pass++;
    interlock = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (mosfet_en === 1'b0) begin n = i; break; end
    end
    n_total++;
    if (n < 1 || n > 4) $display("FAIL ilk_latency: got %0d edges want 1..4", n); else n_pass++;
    step(2);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'h24 || irq !== 1'b1) $display("FAIL ilk_fault: got status=%h irq=%b want 24/1", v, irq); else n_pass++;
    wr(A_CTRL, 32'd2);
    step(2);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'h24) $display("FAIL ilk_clear_blocked: got %h want 24", v); else n_pass++;
    interlock = 1'b0;
    step(4);
    wr(A_CTRL, 32'd2);
    step(2);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'd0 || irq !== 1'b0) $display("FAIL ilk_cleared: got status=%h irq=%b want 0/0", v, irq); else n_pass++;
    step(20);
    n_total++;
    if (mosfet_en !== 1'b0) $display("FAIL ilk_needs_enable: got %b want 0", mosfet_en); else n_pass++;
    wr(A_CTRL, 32'd1);
    step(6);
    n_total++;
    if (mosfet_en !== 1'b1) $display("FAIL ilk_reenable: got %b want 1", mosfet_en); else n_pass++;
    // Interlock held in IDLE only blocks entry to RUN.
    wr(A_CTRL, 32'd0);
    step(3);
    interlock = 1'b1;
    step(4);
    wr(A_CTRL, 32'd1);
    step(20);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'd0) $display("FAIL ilk_idle_block: got %h want 0", v); else n_pass++;
    interlock = 1'b0;
    step(6);
    rd(A_STATUS, v);
    n_total++;
    if ((v & 32'h36) !== 32'h10) $display("FAIL ilk_idle_release: got %h want RUN", v); else n_pass++;
  endtask

  task automatic test_ilk_vs_disable;
    logic [31:0] v;
    step(4);
    interlock = 1'b1;
    step(1);
    wr(A_CTRL, 32'd0);
    step(3);
    rd(A_STATUS, v);
    n_total++;
    if (v !== 32'h24) $display("FAIL ilk_disable_collision: got %h want 24", v); else n_pass++;
    interlock = 1'b0;
    step(4);
    wr(A_CTRL, 32'd2);
    step(2);
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] v;
    configure(10, 12, 100);
    wr(A_CTRL, 32'd1);
    step(6);
    reset = 1'b1;
    step(1);
    n_total++;
    if (mosfet_en !== 1'b0) $display("FAIL reset_run_mosfet: got %b want 0", mosfet_en); else n_pass++;
    step(1);
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), v);
      n_total++;
      if (v !== 32'd0) $display("FAIL reset_run_reg%0d: got %h want 0", a, v); else n_pass++;
      step(1);
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_run_irq: got %b want 0", irq); else n_pass++;
  endtask

  initial begin
    int per;
    int du;
    test_reset();
    test_registers();
    test_pwm(10, 3);
    for (int i = 0; i < 3; i++) begin
      per = $urandom_range(2, 12);
      du  = $urandom_range(1, per - 1);
      test_pwm(per, du);
    end
    test_duty_change();
    test_edge_duties();
    test_watchdog();
    test_wdt_kicks();
    test_interlock();
    test_ilk_vs_disable();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc_system_mosfet_sequencer.md
# soc_system_mosfet_sequencer

Avalon-MM slave that drives the heater MOSFET enable line from a hardware PWM sequencer rather than a bare software-written bit. It adds a software watchdog and a door/over-temperature interlock, so the MOSFET cannot stay on if the HPS stalls or the chamber is opened. It sits on the lightweight HPS-to-FPGA bridge beside the other PIO peripherals in soc_system. Its `mosfet_en` output replaces the direct PIO enable at the top level.

## Interface
Parameters:
- `PRESCALE`, default 50: clk cycles per tick (1 µs at 50 MHz). Must be ≥ 2.
- `WDT_W`, default 24: width of the watchdog timeout register.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high. All state returns to reset values on the next rising edge of `clk`.
- `address`, in, 3: register select.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: combinational read data. Read latency 0, no wait states.
- `interlock`, in, 1: asynchronous; high means unsafe. Synchronized internally through 2 flops.
- `mosfet_en`, out, 1: registered MOSFET gate enable. Reset value 0.
- `irq`, out, 1: registered, high while any fault flag is set. Reset value 0.

## Operation
Register map (write when `chipselect && !write_n`; unused bits read 0):
- 0 CTRL (RW):
  - bit0 `enable`.
  - bit1 `clear_fault`: write-1 pulse, reads 0.
  - bit2 `kick`: write-1 pulse, reads 0.
- 1 PERIOD [15:0] (RW), in ticks.
- 2 DUTY [15:0] (RW), in ticks.
- 3 WDT [WDT_W-1:0] (RW), in ticks. 0 disables the watchdog.
- 4 STATUS (RO):
  - bit0 `mosfet_en`.
  - bit1 `fault_wdt`.
  - bit2 `fault_ilk`.
  - bits[5:4] FSM state (0 IDLE, 1 RUN, 2 FAULT).
- 5–7: read 0, writes ignored.

Reset values: all registers, counters, flags and outputs are 0; FSM is IDLE.

Prescaler:
- Free-running count 0..PRESCALE-1.
- `tick` is a one-clk pulse when the count equals PRESCALE-1.

FSM states:
- IDLE:
  - `mosfet_en` = 0.
  - Goes to RUN when `enable` = 1, no fault flag is set, and synchronized `interlock` = 0.
  - On entry to RUN: `phase` ← 0, `wdt_cnt` ← 0, shadow PERIOD/DUTY ← live registers.
- RUN:
  - `mosfet_en` = (shadow_period ≠ 0) && (`phase` < shadow_duty).
  - When shadow_duty ≥ shadow_period, the output stays on for the whole period.
  - On `tick`: `phase` advances. When `phase` = shadow_period-1 it wraps to 0 and the shadows reload from the live registers. The new PERIOD/DUTY values therefore take effect only at a period boundary.
  - `enable` written 0 → IDLE.
- FAULT:
  - `mosfet_en` = 0 and `enable` is cleared by hardware.
  - Exits to IDLE only on a `clear_fault` write while synchronized `interlock` = 0. That write clears both fault flags.
  - A `clear_fault` write while interlock is high is ignored.

Watchdog (RUN only, WDT ≠ 0):
- `wdt_cnt` increments on `tick`. A `kick` write sets `wdt_cnt` ← 0.
- When `wdt_cnt` reaches WDT: set `fault_wdt` and go to FAULT.

Interlock:
- Synchronized `interlock` = 1 while in RUN: set `fault_ilk` and go to FAULT.
- While in IDLE it only blocks entry to RUN; no flag is set.

Simultaneous events (same edge):
- A fault condition beats `enable` = 0: the fault is latched.
- Interlock and watchdog expiry together: both flags are set.
- `kick` and watchdog expiry together: the kick wins and no fault is set.
- `clear_fault` and a new fault condition together: the fault wins.

Arithmetic: counters are unsigned. `phase` is 16-bit and `wdt_cnt` is WDT_W-bit. Neither counter ever wraps past its compare value.

## Timing
- A CTRL write with `enable` = 1 sampled at edge N:
  - FSM reaches RUN at edge N+1.
  - `mosfet_en` rises at edge N+2 (registered from the next-state/phase decode).
- A fault condition sampled at edge N: FSM reaches FAULT at edge N+1; `mosfet_en` and `irq` update at edge N+2.
- `interlock` path: rising input → synchronized after 2 edges → `mosfet_en` low no later than 4 clk edges after the input rises.
- PWM output: high for shadow_duty×PRESCALE clk and low for (shadow_period−shadow_duty)×PRESCALE clk, ±1 clk of prescaler phase at RUN entry.
- `readdata` is valid in the same cycle as `address`. STATUS reflects register state, not the in-flight write.
- `reset` asserted during RUN: `mosfet_en` = 0 at the next edge, and all registers are cleared.

## Test plan
- **Reset:** assert `reset` 2 clk mid-RUN → `mosfet_en` = 0, STATUS = 0, PERIOD/DUTY/WDT read 0.
- **PWM:** PRESCALE = 50, PERIOD = 10, DUTY = 3, WDT = 0, enable → `mosfet_en` high 150 clk, low 350 clk, repeating. Write DUTY = 7 mid-period → the change applies only from the next period start.
- **Edge duties:**
  - DUTY = 0 → `mosfet_en` never rises.
  - DUTY = 12 with PERIOD = 10 → constant high.
  - PERIOD = 0 → constant low while FSM reads RUN.
- **Watchdog:** WDT = 100, no kick → FAULT after 100 ticks, STATUS = 0x22, `irq` = 1, `mosfet_en` = 0. With kicks every 50 ticks → no fault after 1000 ticks.
- **Interlock:**
  - Raise `interlock` in RUN → `mosfet_en` low within 4 clk, `fault_ilk` = 1.
  - `clear_fault` while interlock is high → still FAULT.
  - Drop interlock, then `clear_fault` → IDLE, `irq` = 0, and `enable` must be rewritten before the output can turn on.
- **Collision:** `kick` on the same edge as watchdog expiry → no fault. Interlock rising on the same edge as `enable` = 0 in RUN → `fault_ilk` is latched.
